// File: rtl/secp256k1_key_export_if.sv
// Host-side word stream for the secp256k1 key exporter.
// Plain valid/ready bus with a frame-end marker.
interface secp256k1_key_export_if #(
    parameter int WORD_W = 32
);
    logic              out_valid;
    logic [WORD_W-1:0] out_data;
    logic              out_ready;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/secp256k1_key_export.sv
// Captures a finished secp256k1 key set and streams it out MSW first, zeroising as it goes.
// Define KEY_EXPORT_PRIV_EN to prepend the private scalar to the exported frame.
module secp256k1_key_export #(
    parameter int KEY_W  = 256,
    parameter int WORD_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       key_valid,
    input  logic [KEY_W-1:0]           priv_key,
    input  logic [KEY_W-1:0]           pub_key_x,
    input  logic [KEY_W-1:0]           pub_key_y,
    output logic                       busy,
    output logic                       overrun,
    secp256k1_key_export_if.master     host
);
`ifdef KEY_EXPORT_PRIV_EN
    localparam int NF = 3;
`else
    localparam int NF = 2;
`endif
    localparam int SW = NF * KEY_W;
    localparam int NW = SW / WORD_W;
    localparam int CW = $clog2(NW);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [SW-1:0]   shreg;
    logic [SW-1:0]   load;
    logic [CW-1:0]   cnt;
    logic            last_word;
    logic            accept;

`ifdef KEY_EXPORT_PRIV_EN
    assign load = {priv_key, pub_key_x, pub_key_y};
`else
    // Private scalar never enters the frame in this build.
    logic unused_priv;
    assign unused_priv = ^priv_key;
    assign load = {pub_key_x, pub_key_y};
`endif

    assign last_word = (cnt == CW'(NW - 1));
    assign accept    = (state == S_SEND) && host.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (key_valid) state_nxt = S_SEND;
            S_SEND: if (accept && last_word && !key_valid) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        host.out_valid = 1'b0;
        host.out_last  = 1'b0;
        host.out_data  = shreg[SW-1 -: WORD_W];
        busy           = 1'b0;
        if (state == S_SEND) begin
            host.out_valid = 1'b1;
            host.out_last  = last_word;
            busy           = 1'b1;
        end
    end

    // A fresh key set may only land in idle or on the closing handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            cnt     <= '0;
            overrun <= 1'b0;
        end else if (state == S_IDLE) begin
            if (key_valid) begin
                shreg <= load;
                cnt   <= '0;
            end
        end else begin
            if (accept && last_word && key_valid) begin
                shreg <= load;
                cnt   <= '0;
            end else if (accept) begin
                shreg <= {shreg[SW-WORD_W-1:0], {WORD_W{1'b0}}};
                cnt   <= last_word ? '0 : cnt + CW'(1);
            end
            if (key_valid && !(accept && last_word)) begin
                overrun <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_secp256k1_key_export.sv
// Scoreboard bench for secp256k1_key_export: vector table plus
// back-to-back, overrun and mid-frame reset sequences.
module tb_secp256k1_key_export;
    localparam int KW = 256;
    localparam int WW = 32;
`ifdef KEY_EXPORT_PRIV_EN
    localparam int NF = 3;
`else
    localparam int NF = 2;
`endif
    localparam int SW = NF * KW;
    localparam int NW = SW / WW;

    localparam logic [KW-1:0] GX =
        256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
    localparam logic [KW-1:0] GY =
        256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;

    typedef struct {
        logic [WW-1:0] data;
        logic          last;
    } exp_t;

    typedef struct {
        logic [KW-1:0] priv;
        logic [KW-1:0] x;
        logic [KW-1:0] y;
        int            mode;
    } vec_t;

    typedef struct {
        int            idx;
        logic [WW-1:0] word;
    } spot_t;

    logic          clk;
    logic          rst_n;
    logic          key_valid;
    logic [KW-1:0] priv_key;
    logic [KW-1:0] pub_key_x;
    logic [KW-1:0] pub_key_y;
    logic          busy;
    logic          overrun;

    secp256k1_key_export_if #(.WORD_W(WW)) bus ();

    secp256k1_key_export #(.KEY_W(KW), .WORD_W(WW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .priv_key  (priv_key),
        .pub_key_x (pub_key_x),
        .pub_key_y (pub_key_y),
        .busy      (busy),
        .overrun   (overrun),
        .host      (bus)
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    int            hs_cnt   = 0;
    int            mode     = 0;
    exp_t          q[$];
    logic [WW-1:0] rx[$];
    logic          stall    = 1'b0;
    logic [WW-1:0] stall_data;
    logic          stall_last;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [SW-1:0] frame_of(input logic [KW-1:0] p,
                                               input logic [KW-1:0] x,
                                               input logic [KW-1:0] y);
`ifdef KEY_EXPORT_PRIV_EN
        return {p, x, y};
`else
        logic unused_p;
        unused_p = ^p;
        return {x, y};
`endif
    endfunction

    task automatic push_frame(input logic [KW-1:0] p, input logic [KW-1:0] x,
                              input logic [KW-1:0] y);
        logic [SW-1:0] f;
        exp_t          e;
        f = frame_of(p, x, y);
        for (int i = 0; i < NW; i++) begin
            e.data = f[SW-1-WW*i -: WW];
            e.last = (i == NW - 1);
            q.push_back(e);
        end
    endtask

    task automatic pulse_key(input logic [KW-1:0] p, input logic [KW-1:0] x,
                             input logic [KW-1:0] y, input bit captured);
        priv_key  = p;
        pub_key_x = x;
        pub_key_y = y;
        key_valid = 1'b1;
        if (captured) push_frame(p, x, y);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            #1;
            if (q.size() == 0 && !busy) return;
        end
        chk("frame_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_hs(input int n);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            #1;
            if (hs_cnt == n) return;
        end
        chk("hs_wait_timeout", 64'(hs_cnt), 64'(n));
    endtask

    always @(posedge clk) begin
        #1;
        if (mode == 1) bus.out_ready = ~bus.out_ready;
        else           bus.out_ready = 1'b1;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                chk("stall_hold", {30'd0, bus.out_valid, bus.out_last, bus.out_data},
                    {30'd0, 1'b1, stall_last, stall_data});
            end
            if (bus.out_valid && bus.out_ready) begin
                exp_t e;
                hs_cnt++;
                rx.push_back(bus.out_data);
                if (q.size() == 0) begin
                    chk("sb_underflow", 64'(bus.out_data), 64'hDEAD);
                end else begin
                    e = q.pop_front();
                    chk("word_data", 64'(bus.out_data), 64'(e.data));
                    chk("word_last", 64'(bus.out_last), 64'(e.last));
                end
            end
            stall      = bus.out_valid && !bus.out_ready;
            stall_data = bus.out_data;
            stall_last = bus.out_last;
        end
    end

    vec_t          vecs[5];
    spot_t         spots[$];
    logic [KW-1:0] r0;
    logic [KW-1:0] r1;
    logic [KW-1:0] r2;
    logic [KW-1:0] nx;
    logic [SW-1:0] nf;

    initial begin
        for (int i = 0; i < 8; i++) begin
            r0 = {r0[KW-33:0], $urandom()};
            r1 = {r1[KW-33:0], $urandom()};
            r2 = {r2[KW-33:0], $urandom()};
        end
        vecs[0] = '{256'd1, GX, GY, 0};
        vecs[1] = '{256'd1, GX, GY, 1};
        vecs[2] = '{{KW{1'b1}}, {KW{1'b1}}, {KW{1'b1}}, 0};
        vecs[3] = '{{64{4'hA}}, {64{4'h5}}, {64{4'hC}}, 1};
        vecs[4] = '{r0, r1, r2, 0};
`ifdef KEY_EXPORT_PRIV_EN
        spots.push_back('{0, 32'h0});
        spots.push_back('{6, 32'h0});
        spots.push_back('{7, 32'h1});
        spots.push_back('{8, 32'h79BE667E});
        spots.push_back('{16, 32'h483ADA77});
        spots.push_back('{23, 32'hFB10D4B8});
`else
        spots.push_back('{0, 32'h79BE667E});
        spots.push_back('{7, 32'h16F81798});
        spots.push_back('{8, 32'h483ADA77});
        spots.push_back('{15, 32'hFB10D4B8});
`endif

        rst_n        = 1'b0;
        key_valid    = 1'b0;
        priv_key     = '0;
        pub_key_x    = '0;
        pub_key_y    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("reset_idle", {bus.out_valid, bus.out_data, busy, overrun}, 64'd0);
        end

        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            mode   = vecs[i].mode;
            hs_cnt = 0;
            rx.delete();
            pulse_key(vecs[i].priv, vecs[i].x, vecs[i].y, 1'b1);
            chk("latency_valid", 64'(bus.out_valid), 64'd1);
            wait_idle();
            chk("frame_hs_count", 64'(hs_cnt), 64'(NW));
            if (vecs[i].x == GX) begin
                foreach (spots[k]) begin
                    if (spots[k].idx < rx.size())
                        chk("gen_point_word", 64'(rx[spots[k].idx]), 64'(spots[k].word));
                    else
                        chk("gen_point_missing", 64'(rx.size()), 64'(NW));
                end
            end
        end
        mode = 0;

        // Back-to-back frame: new key lands on the closing handshake.
        @(posedge clk);
        #1;
        hs_cnt = 0;
        pulse_key(256'd1, GX, GY, 1'b1);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bus.out_last && bus.out_ready) break;
        end
        nx = {32'hC0FFEE01, 224'h1};
        pulse_key(nx, nx, GY, 1'b1);
        nf = frame_of(nx, nx, GY);
        @(negedge clk);
        chk("b2b_no_gap", 64'(bus.out_valid), 64'd1);
        chk("b2b_word0", 64'(bus.out_data), 64'(nf[SW-1 -: WW]));
        chk("b2b_overrun", 64'(overrun), 64'd0);
        wait_idle();
        chk("b2b_hs_count", 64'(hs_cnt), 64'(2 * NW));

        // Dropped key mid-frame.
        @(posedge clk);
        #1;
        hs_cnt = 0;
        pulse_key(r0, r1, r2, 1'b1);
        wait_hs(3);
        pulse_key(GX, GY, GX, 1'b0);
        chk("overrun_set", 64'(overrun), 64'd1);
        wait_idle();
        chk("overrun_hs_count", 64'(hs_cnt), 64'(NW));
        repeat (3) @(negedge clk);
        chk("overrun_sticky", {busy, overrun}, 64'b01);

        // Reset mid-frame.
        @(posedge clk);
        #1;
        hs_cnt = 0;
        pulse_key(256'd1, GX, GY, 1'b1);
        wait_hs(5);
        rst_n = 1'b0;
        #1;
        chk("async_abort", {bus.out_valid, busy}, 64'd0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset", {bus.out_valid, bus.out_data, busy, overrun}, 64'd0);
        @(posedge clk);
        #1;
        hs_cnt = 0;
        rx.delete();
        pulse_key(r2, r0, r1, 1'b1);
        wait_idle();
        chk("restart_hs_count", 64'(hs_cnt), 64'(NW));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
